// File: rtl/matmul_pkg.sv
// matmul_pkg
// Shared types and defaults for the matrix-multiply sequencer slice:
// the 8-bit element type, the sequencer state encoding and the default
// matrix dimension.
package matmul_pkg;

    typedef logic [7:0] elem_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } seq_state_t;

    localparam int MATMUL_N = 3;

    // Width of a row/column index for an n-by-n matrix, never zero
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// matmul_sequencer_if
// Bus between the sequencer and the shared dot-product engine. The
// sequencer is the master: it presents a row/column pair with a one-cycle
// request, and the engine answers later with a valid-qualified 8-bit sum.
interface matmul_sequencer_if import matmul_pkg::*; #(
    parameter int N = MATMUL_N
) ();

    elem_t [N-1:0] dp_row;
    elem_t [N-1:0] dp_col;
    logic          dp_axiiv;
    logic          dp_axiov;
    elem_t         dp_axiod;

    modport master (
        output dp_row,
        output dp_col,
        output dp_axiiv,
        input  dp_axiov,
        input  dp_axiod
    );

    modport slave (
        input  dp_row,
        input  dp_col,
        input  dp_axiiv,
        output dp_axiov,
        output dp_axiod
    );

endinterface

// File: rtl/matmul_watchdog.sv
// matmul_watchdog
// Counts cycles spent waiting for an engine response. Cleared while a
// request is being issued, advances while enabled, and flags expiry during
// the LIMIT-th enabled cycle so the sequencer can bail out that same cycle.
module matmul_watchdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // Cycle counter: restarts on clear, saturates once the limit is reached
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer
// Computes C = A x B for N-by-N 8-bit matrices on one external dot-product
// engine. Operands are latched on a start strobe, then each (row i of A,
// column j of B) pair is issued to the engine in row-major order and the
// returned sums are stored into C. A one-cycle axiov pulse marks completion.
//
// Build option: define MATMUL_SEQ_WATCHDOG_EN to add a wait-state timeout
// that raises a sticky error and abandons the remaining elements.
module matmul_sequencer import matmul_pkg::*; #(
    parameter int N              = MATMUL_N,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     axiiv,
    input  elem_t [N-1:0][N-1:0]     a_mat,
    input  elem_t [N-1:0][N-1:0]     b_mat,
    output logic                     axiov,
    output elem_t [N-1:0][N-1:0]     c_mat,
    output logic                     busy,
    output logic                     error,
    matmul_sequencer_if.master       dp
);

    localparam int IW = index_width(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    seq_state_t state, state_next;

    elem_t [N-1:0][N-1:0] a_buf;
    elem_t [N-1:0][N-1:0] b_buf;
    logic  [IW-1:0]       i_idx;
    logic  [IW-1:0]       j_idx;

    logic start_accept;
    logic store;
    logic advance;
    logic last_elem;
    logic wd_expired;

    assign last_elem = (i_idx == LAST_IDX) && (j_idx == LAST_IDX);

`ifdef MATMUL_SEQ_WATCHDOG_EN
    logic wd_clear;
    logic wd_enable;
    logic timeout;

    assign wd_clear  = (state == S_ISSUE);
    assign wd_enable = (state == S_WAIT);
    // A response in the expiring cycle still counts; only silence times out
    assign timeout   = (state == S_WAIT) && !dp.dp_axiov && wd_expired;

    matmul_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Sticky error: set on a timeout, cleared only by the next accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            error <= 1'b0;
        end else if (start_accept) begin
            error <= 1'b0;
        end else if (timeout) begin
            error <= 1'b1;
        end
    end
`else
    assign wd_expired = 1'b0;
    assign error      = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode; engine response is only honoured in WAIT
    always_comb begin
        state_next   = state;
        dp.dp_axiiv  = 1'b0;
        axiov        = 1'b0;
        busy         = 1'b1;
        start_accept = 1'b0;
        store        = 1'b0;
        advance      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (axiiv) begin
                    start_accept = 1'b1;
                    state_next   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                dp.dp_axiiv = 1'b1;
                state_next  = S_WAIT;
            end
            S_WAIT: begin
                if (dp.dp_axiov) begin
                    store = 1'b1;
                    if (last_elem) begin
                        state_next = S_DONE;
                    end else begin
                        advance    = 1'b1;
                        state_next = S_ISSUE;
                    end
                end else if (wd_expired) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                axiov      = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand buffers, result matrix and row-major element indices
    always_ff @(posedge clk) begin
        if (rst) begin
            a_buf <= '0;
            b_buf <= '0;
            c_mat <= '0;
            i_idx <= '0;
            j_idx <= '0;
        end else begin
            if (start_accept) begin
                a_buf <= a_mat;
                b_buf <= b_mat;
                c_mat <= '0;
                i_idx <= '0;
                j_idx <= '0;
            end
            if (store) begin
                c_mat[i_idx][j_idx] <= dp.dp_axiod;
            end
            if (advance) begin
                if (j_idx == LAST_IDX) begin
                    j_idx <= '0;
                    i_idx <= i_idx + 1'b1;
                end else begin
                    j_idx <= j_idx + 1'b1;
                end
            end
        end
    end

    // Engine operands: row i of A and column j of B, held while indices are stable
    always_comb begin
        dp.dp_row = a_buf[i_idx];
        dp.dp_col = '0;
        for (int k = 0; k < N; k++) begin
            dp.dp_col[k] = b_buf[k][j_idx];
        end
    end

endmodule
